// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: one DIGIT-bit ripple slice time-shared over
// WIDTH/DIGIT clocks, with start/busy/done handshake and held result flags.
module serial_addsub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = $clog2(N) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             load_c;
  logic             step_c;
  logic             last_c;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic             rip;
  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic             dig_cmsb;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == CW'(N - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control strobes for the datapath
  always_comb begin
    load_c = 1'b0;
    step_c = 1'b0;
    last_c = 1'b0;
    case (state)
      IDLE:    load_c = start;
      RUN: begin
        step_c = 1'b1;
        last_c = (cnt == CW'(N - 1));
      end
      default: ;
    endcase
  end

  // DIGIT-bit ripple slice; dig_cmsb is the carry into the slice's top bit,
  // which on the final digit is the carry into bit WIDTH-1.
  always_comb begin
    rip      = carry;
    dig_sum  = '0;
    dig_cmsb = 1'b0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      dig_cmsb   = rip;
      dig_sum[i] = opa[i] ^ opb[i] ^ rip;
      rip        = (opa[i] & opb[i]) | (rip & (opa[i] ^ opb[i]));
    end
    dig_cout = rip;
    res_next = WIDTH'({dig_sum, res} >> DIGIT);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      cnt       <= '0;
      opa       <= '0;
      opb       <= '0;
      res       <= '0;
      carry     <= 1'b0;
    end else begin
      done <= last_c;
      if (load_c) begin
        opa   <= a;
        opb   <= sub ? ~b : b;
        carry <= sub;
        cnt   <= '0;
        busy  <= 1'b1;
      end else if (step_c) begin
        opa   <= opa >> DIGIT;
        opb   <= opb >> DIGIT;
        carry <= dig_cout;
        res   <= res_next;
        cnt   <= cnt + CW'(1);
        if (last_c) begin
          sum       <= res_next;
          carry_out <= dig_cout;
          overflow  <= dig_cmsb ^ dig_cout;
          busy      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: 8-bit/1-bit-digit and 4-bit/2-bit-digit
// instances against an arithmetic reference model.
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst_n;
  always #5 clk = ~clk;

  logic       start8, sub8, busy8, done8, co8, ov8;
  logic [7:0] a8, b8, sum8;
  logic       start4, sub4, busy4, done4, co4, ov4;
  logic [3:0] a4, b4, sum4;

  int vectors = 0;
  int fails   = 0;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8), .overflow(ov8)
  );

  serial_addsub #(.WIDTH(4), .DIGIT(2)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .carry_out(co4), .overflow(ov4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_busy(input int inst);
    return (inst == 8) ? busy8 : busy4;
  endfunction
  function automatic logic get_done(input int inst);
    return (inst == 8) ? done8 : done4;
  endfunction
  function automatic logic [7:0] get_sum(input int inst);
    return (inst == 8) ? sum8 : {4'h0, sum4};
  endfunction
  function automatic logic [1:0] get_flags(input int inst);
    return (inst == 8) ? {ov8, co8} : {ov4, co4};
  endfunction

  task automatic drive(input int inst, input logic st, input logic s,
                       input logic [7:0] a, input logic [7:0] b);
    if (inst == 8) begin
      start8 = st; sub8 = s; a8 = a; b8 = b;
    end else begin
      start4 = st; sub4 = s; a4 = a[3:0]; b4 = b[3:0];
    end
  endtask

  // Reference: plain signed/unsigned arithmetic. Returns {ov, co, sum}.
  function automatic logic [9:0] model(input int w, input int a, input int b, input bit s);
    int m, h, sa, sb, r, sm;
    bit co, ov;
    m  = 1 << w;
    h  = m / 2;
    sm = s ? (a - b + m) % m : (a + b) % m;
    co = s ? (a >= b) : ((a + b) >= m);
    sa = (a >= h) ? a - m : a;
    sb = (b >= h) ? b - m : b;
    r  = s ? sa - sb : sa + sb;
    ov = (r < -h) || (r >= h);
    return {ov, co, 8'(sm)};
  endfunction

  // Issues one operation, optionally pulses a spurious start at cycle inj,
  // optionally checks the previous sum is held, and checks the result.
  task automatic op(input int inst, input logic [7:0] a, input logic [7:0] b,
                    input logic s, input int inj, input logic [7:0] hold,
                    input bit chk_hold);
    int n, lat, bcnt;
    bit held;
    logic [9:0] exp;
    n = (inst == 8) ? 8 : 2;
    drive(inst, 1'b1, s, a, b);
    @(posedge clk); #1;
    drive(inst, 1'b0, ~s, 8'($urandom), 8'($urandom));
    check("done_low_after_start", 32'(get_done(inst)), 32'd0);
    bcnt = int'(get_busy(inst));
    lat  = 0;
    held = 1'b1;
    while (!get_done(inst) && lat < 40) begin
      if (inst == 8) start8 = (lat == inj);
      else           start4 = (lat == inj);
      if (lat == inj) begin
        a8 = 8'hAA; b8 = 8'h55;
      end
      if (chk_hold && get_sum(inst) !== hold) held = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (get_busy(inst)) bcnt++;
    end
    if (inst == 8) start8 = 1'b0;
    else           start4 = 1'b0;
    exp = model(inst, int'(a), int'(b), s);
    check("latency", 32'(lat), 32'(n));
    check("busy_cycles", 32'(bcnt), 32'(n));
    if (chk_hold) check("sum_held", 32'(held), 32'd1);
    check("sum", 32'(get_sum(inst)), 32'(exp[7:0]));
    check("flags_ov_co", 32'(get_flags(inst)), 32'(exp[9:8]));
  endtask

  initial begin
    int quiet;
    rst_n = 1'b0;
    drive(8, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(4, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_out8", 32'({sum8, co8, ov8}), 32'd0);
    check("rst_out4", 32'({busy4, done4, sum4, co4, ov4}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed 8-bit cases
    op(8, 8'h0F, 8'h01, 1'b0, -1, 8'h00, 1'b1);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done8), 32'd0);
    check("sum_held_idle", 32'(sum8), 32'h10);
    op(8, 8'hFF, 8'h01, 1'b0, -1, 8'h00, 1'b0);
    op(8, 8'h7F, 8'h01, 1'b0, -1, 8'h00, 1'b0);
    op(8, 8'h05, 8'h07, 1'b1, -1, 8'h00, 1'b0);
    op(8, 8'h80, 8'h01, 1'b1, -1, 8'h00, 1'b0);

    // Ignored start while busy, then back-to-back start in the done cycle
    op(8, 8'h10, 8'h20, 1'b0, 3, 8'h00, 1'b0);
    op(8, 8'h01, 8'h01, 1'b0, -1, 8'h30, 1'b1);
    @(posedge clk); #1;

    // Asynchronous reset mid-operation
    drive(8, 1'b1, 1'b0, 8'h11, 8'h22);
    @(posedge clk); #1;
    drive(8, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy8), 32'd0);
    check("async_rst_sum", 32'(sum8), 32'd0);
    check("async_rst_flags", 32'({done8, co8, ov8}), 32'd0);
    #3 rst_n = 1'b1;
    quiet = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done8 || busy8) quiet++;
    end
    check("no_done_after_rst", 32'(quiet), 32'd0);
    op(8, 8'h03, 8'h04, 1'b0, -1, 8'h00, 1'b0);

    // Randomized 8-bit operations
    for (int k = 0; k < 60; k++) begin
      op(8, 8'($urandom), 8'($urandom), 1'($urandom), -1, 8'h00, 1'b0);
    end

    // Exhaustive 4-bit, 2-bit digit
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        for (int s = 0; s < 2; s++)
          op(4, 8'(i), 8'(j), 1'(s), -1, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
